// File: rtl/smem_pkg.sv
// Shared definitions for the occurrence-table request path: default geometry and
// scheduler state encoding.
package smem_pkg;

  localparam int unsigned DEPTH_DEF  = 4;
  localparam int unsigned ADDR_W_DEF = 42;
  localparam int unsigned TAG_W_DEF  = 9;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StIssueK = 2'd1,
    StIssueL = 2'd2
  } sched_state_e;

endpackage

// File: rtl/req_fifo.sv
// Synchronous FIFO with occupancy count; a push into a full FIFO is accepted only
// when it coincides with a pop.
module req_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       push_ok,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic [$clog2(DEPTH):0]     count_next
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    count_next = count_q;
    if (push_ok && !pop_ok) begin
      count_next = count_q + CW'(1);
    end else if (!push_ok && pop_ok) begin
      count_next = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_next;
    end
  end

  // Storage needs no reset; count gates every read of it.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/occ_req_sched.sv
// Occurrence-table request scheduler: queues k/l line address pairs and issues
// them to memory one address per beat, merging equal k/l into a single beat.
module occ_req_sched
  import smem_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned TAG_W  = TAG_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr_k,
  input  logic [ADDR_W-1:0] req_addr_l,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              stall,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [TAG_W-1:0]  mem_req_tag,
  output logic              mem_req_sel,
  output logic              mem_req_both,
  output logic              overflow
);

  localparam int unsigned EW = 2 * ADDR_W + TAG_W;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  sched_state_e state_q, state_d;

  logic [EW-1:0]     fifo_wdata, fifo_rdata;
  logic              fifo_pop, fifo_push_ok, fifo_empty, fifo_full;
  logic [CW-1:0]     fifo_count, fifo_count_next;
  logic [ADDR_W-1:0] head_k, head_l;
  logic [TAG_W-1:0]  head_tag;
  logic              handshake, more_after_pop;
  logic              stall_q, overflow_q;

  assign fifo_wdata = {req_addr_k, req_addr_l, req_tag};

  req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_req_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (req_valid),
    .wdata      (fifo_wdata),
    .pop        (fifo_pop),
    .rdata      (fifo_rdata),
    .push_ok    (fifo_push_ok),
    .empty      (fifo_empty),
    .full       (fifo_full),
    .count      (fifo_count),
    .count_next (fifo_count_next)
  );

  assign head_k   = fifo_rdata[EW-1 -: ADDR_W];
  assign head_l   = fifo_rdata[TAG_W +: ADDR_W];
  assign head_tag = fifo_rdata[TAG_W-1:0];

  assign handshake = mem_req_valid && mem_req_ready;
  // A push landing on the same edge as the last pop keeps the issue stream going.
  assign more_after_pop = (fifo_count > CW'(1)) || fifo_push_ok;

  always_comb begin
    state_d       = state_q;
    fifo_pop      = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    mem_req_tag   = '0;
    mem_req_sel   = 1'b0;
    mem_req_both  = 1'b0;
    case (state_q)
      StIdle: begin
        if (!fifo_empty || fifo_push_ok) state_d = StIssueK;
      end
      StIssueK: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = head_k;
        mem_req_tag   = head_tag;
        mem_req_both  = (head_k == head_l);
        if (handshake) begin
          if (mem_req_both) begin
            fifo_pop = 1'b1;
            state_d  = more_after_pop ? StIssueK : StIdle;
          end else begin
            state_d = StIssueL;
          end
        end
      end
      StIssueL: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = head_l;
        mem_req_tag   = head_tag;
        mem_req_sel   = 1'b1;
        if (handshake) begin
          fifo_pop = 1'b1;
          state_d  = more_after_pop ? StIssueK : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      stall_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      // Leaves one slot free for the request already in flight upstream.
      stall_q    <= (fifo_count_next >= CW'(DEPTH - 1));
      overflow_q <= overflow_q | (req_valid & ~fifo_push_ok);
    end
  end

  assign stall    = stall_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_occ_req_sched.sv
// Bench for occ_req_sched: directed scenarios plus random traffic against a
// queue-based reference model of the request stream.
module tb_occ_req_sched;
  import smem_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 42;
  localparam int unsigned TW    = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic [AW-1:0] req_addr_k, req_addr_l;
  logic [TW-1:0] req_tag;
  logic          stall, mem_req_valid, mem_req_ready, mem_req_sel, mem_req_both, overflow;
  logic [AW-1:0] mem_req_addr;
  logic [TW-1:0] mem_req_tag;

  occ_req_sched #(
    .DEPTH  (DEPTH),
    .ADDR_W (AW),
    .TAG_W  (TW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_addr_k    (req_addr_k),
    .req_addr_l    (req_addr_l),
    .req_tag       (req_tag),
    .stall         (stall),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_req_tag   (mem_req_tag),
    .mem_req_sel   (mem_req_sel),
    .mem_req_both  (mem_req_both),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] k;
    logic [AW-1:0] l;
    logic [TW-1:0] tag;
  } ent_t;

  // Reference: queue of accepted entries, whether head's k beat is already out,
  // sticky overflow, and a log of issued beats (tag*2 + sel).
  ent_t q[$];
  bit   half;
  bit   m_ovf;
  int   issued[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic chk_reset_values();
    chk("rst_stall", stall, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_valid", mem_req_valid, 0);
    chk("rst_addr", mem_req_addr, 0);
    chk("rst_tag", mem_req_tag, 0);
    chk("rst_sel", mem_req_sel, 0);
    chk("rst_both", mem_req_both, 0);
  endtask

  task automatic check_outputs();
    ent_t h;
    chk("valid", mem_req_valid, q.size() > 0);
    if (q.size() > 0) begin
      h = q[0];
      chk("addr", mem_req_addr, half ? h.l : h.k);
      chk("tag", mem_req_tag, h.tag);
      chk("sel", mem_req_sel, half);
      chk("both", mem_req_both, !half && (h.k == h.l));
    end
    chk("stall", stall, q.size() >= DEPTH - 1);
    chk("overflow", overflow, m_ovf);
  endtask

  task automatic step(input bit rv, input logic [AW-1:0] k, input logic [AW-1:0] l,
                      input logic [TW-1:0] tag, input bit rdy);
    bit   pop, push_ok;
    ent_t h, e;
    req_valid     = rv;
    req_addr_k    = k;
    req_addr_l    = l;
    req_tag       = tag;
    mem_req_ready = rdy;
    @(posedge clk);
    pop = 0;
    if (q.size() > 0 && rdy) begin
      h = q[0];
      if (!half && h.k != h.l) begin
        issued.push_back(int'(h.tag) * 2);
        half = 1;
      end else begin
        issued.push_back(int'(h.tag) * 2 + int'(half));
        half = 0;
        pop  = 1;
      end
    end
    push_ok = rv && (q.size() < DEPTH || pop);
    if (rv && !push_ok) m_ovf = 1;
    if (pop) void'(q.pop_front());
    if (push_ok) begin
      e.k = k; e.l = l; e.tag = tag;
      q.push_back(e);
    end
    #1;
    check_outputs();
  endtask

  task automatic idle(input bit rdy);
    step(0, '0, '0, '0, rdy);
  endtask

  // Asynchronous reset applied mid-cycle; outputs must clear before any edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk_reset_values();
    #2;
    rst = 1'b0;
    q.delete();
    half  = 0;
    m_ovf = 0;
  endtask

  initial begin
    logic [63:0] r;
    logic [AW-1:0] rk, rl;
    int exp_log[6] = '{2, 3, 4, 5, 6, 7};
    int guard;

    rst = 1'b1; req_valid = 0; req_addr_k = '0; req_addr_l = '0; req_tag = '0;
    mem_req_ready = 0;
    #12;
    chk_reset_values();
    rst = 1'b0;
    half = 0; m_ovf = 0;

    // Single entry, distinct k/l: k beat then l beat, then idle
    step(1, 42'h100, 42'h104, 9'd5, 1);
    chk("d1_k_addr", mem_req_addr, 42'h100);
    chk("d1_k_sel", mem_req_sel, 0);
    idle(1);
    chk("d1_l_addr", mem_req_addr, 42'h104);
    chk("d1_l_sel", mem_req_sel, 1);
    idle(1);
    chk("d1_idle", mem_req_valid, 0);

    // k == l: one merged beat
    step(1, 42'h200, 42'h200, 9'd7, 1);
    chk("d2_both", mem_req_both, 1);
    chk("d2_addr", mem_req_addr, 42'h200);
    idle(1);
    chk("d2_empty", mem_req_valid, 0);

    // Backpressure: request held stable while ready is low
    step(1, 42'h300, 42'h304, 9'd9, 0);
    for (int i = 0; i < 5; i++) begin
      idle(0);
      chk("d3_hold_addr", mem_req_addr, 42'h300);
      chk("d3_hold_tag", mem_req_tag, 9'd9);
    end
    idle(1);
    chk("d3_l_addr", mem_req_addr, 42'h304);
    idle(1);
    idle(1);

    // Fill to full with ready low; fifth push overflows
    for (int i = 0; i < 5; i++) begin
      step(1, AW'(16 * i), AW'(16 * i + 8), TW'(10 + i), 0);
      if (i == 1) chk("d4_stall_lo", stall, 0);
      if (i == 2) chk("d4_stall_hi", stall, 1);
      if (i == 3) chk("d4_ovf_lo", overflow, 0);
    end
    chk("d4_ovf_hi", overflow, 1);
    for (int i = 0; i < 10; i++) idle(1);
    chk("d4_ovf_sticky", overflow, 1);
    do_reset();

    // Ordering with random ready
    issued.delete();
    for (int i = 1; i <= 3; i++) step(1, AW'(i * 64), AW'(i * 64 + 4), TW'(i), $urandom_range(0, 1) == 1);
    guard = 0;
    while (q.size() > 0 && guard < 60) begin
      idle($urandom_range(0, 1) == 1);
      guard++;
    end
    chk("d5_drained", q.size() == 0, 1);
    chk("d5_count", issued.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < issued.size()) chk("d5_order", issued[i], exp_log[i]);
    end

    // Reset while in the l beat with two entries queued
    step(1, 42'h500, 42'h504, 9'd20, 0);
    step(1, 42'h600, 42'h604, 9'd21, 1);
    idle(0);
    chk("d6_in_l", mem_req_sel, 1);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("d6_quiet", mem_req_valid, 0);
    end

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      r  = {$urandom(), $urandom()};
      rk = r[AW-1:0];
      r  = {$urandom(), $urandom()};
      rl = ($urandom_range(0, 3) == 0) ? rk : r[AW-1:0];
      if (i == 200) do_reset();
      step($urandom_range(0, 9) < 6, rk, rl, TW'($urandom()), $urandom_range(0, 9) < 7);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/occ_req_sched.md
OCC_REQ_SCHED -- requirements
Module: occ_req_sched

Interface
REQ-001 Parameter DEPTH, default 4: request FIFO entries, power of two, minimum 4.
REQ-002 Parameter ADDR_W, default 42: occurrence-table line address width.
REQ-003 Parameter TAG_W, default 9: read-number tag width.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous and active-high.
REQ-006 Port req_valid, input, 1: backward-extension stage presents a k/l address pair this cycle.
REQ-007 Port req_addr_k, input, ADDR_W: line address for k.
REQ-008 Port req_addr_l, input, ADDR_W: line address for l.
REQ-009 Port req_tag, input, TAG_W: read number of the requesting read.
REQ-010 Port stall, output, 1: pipeline hold to the upstream stages.
REQ-011 Port mem_req_valid, output, 1: memory read request valid.
REQ-012 Port mem_req_ready, input, 1: memory port accepts the request.
REQ-013 Port mem_req_addr, output, ADDR_W: address being issued.
REQ-014 Port mem_req_tag, output, TAG_W: tag of the issued address.
REQ-015 Port mem_req_sel, output, 1: 0 = k address, 1 = l address.
REQ-016 Port mem_req_both, output, 1: issued line serves both k and l (addresses equal).
REQ-017 Port overflow, output, 1: sticky error, request arrived while FIFO full.

Function
REQ-018 Accept (push) on req_valid && FIFO not full; entry = {addr_k, addr_l, tag}.
REQ-019 stall = (count >= DEPTH-1), registered, so the one request already in flight upstream always lands.
REQ-020 req_valid while full: request dropped, overflow set and held until reset; count unchanged.
REQ-021 FSM states IDLE, ISSUE_K, ISSUE_L; IDLE -> ISSUE_K when FIFO non-empty.
REQ-022 ISSUE_K: mem_req_valid=1, addr=head.addr_k, sel=0, both=(head.addr_k==head.addr_l).
REQ-023 ISSUE_K handshake with both=1: pop head; go to ISSUE_K if FIFO still non-empty, else IDLE.
REQ-024 ISSUE_K handshake with both=0: go to ISSUE_L, no pop.
REQ-025 ISSUE_L: mem_req_valid=1, addr=head.addr_l, sel=1, both=0; on handshake pop, then ISSUE_K if non-empty else IDLE.
REQ-026 Handshake = mem_req_valid && mem_req_ready; while not ready all mem_req_* held stable, valid never drops.
REQ-027 No combinational path from req_* to mem_req_*; first mem_req_valid earliest one cycle after push into empty FIFO.
REQ-028 Push and pop in the same cycle: count unchanged, both take effect; push allowed when full only if it coincides with a pop.
REQ-029 Pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
REQ-030 Strict FIFO order; tags leave in acceptance order, k before l per entry.
REQ-031 Throughput: one address per cycle with mem_req_ready held high.

Reset
REQ-032 On rst: FIFO empty, pointers 0, state IDLE, stall=0, overflow=0, mem_req_valid=0, mem_req_addr=0, mem_req_tag=0, mem_req_sel=0, mem_req_both=0.
REQ-033 Reset mid-issue drops all queued and partially issued entries; no request is issued after reset until a new push.

Structure
REQ-034 FSM state encoding and the DEPTH/ADDR_W/TAG_W defaults live in the shared smem package.
REQ-035 One sub-module, req_fifo (synchronous FIFO with count), instantiated once; the FSM is in occ_req_sched.

Verification
REQ-036 Push one entry (k=0x100, l=0x104, tag=5) with ready=1 -> cycle+1 addr 0x100 sel=0, cycle+2 addr 0x104 sel=1, then idle.
REQ-037 Push k=l=0x200, tag=7 -> exactly one beat, addr 0x200, both=1, FIFO empty after it.
REQ-038 Hold ready=0 for 5 cycles during ISSUE_K -> valid/addr/tag stable all 5 cycles; issue completes after ready rises.
REQ-039 DEPTH=4, ready=0, push every cycle -> stall rises when count reaches 3; fifth push sets overflow, count stays 4.
REQ-040 Pushes with tags 1,2,3 interleaved with random ready -> issue order 1k,1l,2k,2l,3k,3l.
REQ-041 Assert rst while in ISSUE_L with 2 entries queued -> all outputs at reset values immediately; nothing issued until next push.
